// File: rtl/dma_dev_port.sv
// Device-side port for dma_controller: turns a local command plus word streams into the
// controller's rqst/dev_ack/dma_ack/end_flag handshake through a shared 2-entry FIFO.
module dma_dev_port #(
    parameter int unsigned ADD_LEN  = 16,
    parameter int unsigned DATA_LEN = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_rd_wr,
    input  logic [ADD_LEN:0]    cmd_addr,
    input  logic [ADD_LEN-1:0]  cmd_words,
    input  logic [DATA_LEN-1:0] src_data,
    input  logic                src_valid,
    output logic                src_ready,
    output logic [DATA_LEN-1:0] snk_data,
    output logic                snk_valid,
    input  logic                snk_ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                rqst,
    output logic                rd_wr,
    output logic [ADD_LEN:0]    start_addr,
    output logic [ADD_LEN-1:0]  num_words,
    output logic                dev_ack,
    output logic [DATA_LEN-1:0] dev_in,
    input  logic                dma_ack,
    input  logic [DATA_LEN-1:0] dev_out,
    input  logic                end_flag
);

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StFin} state_e;

    state_e              state_q, state_d;
    logic                rd_wr_q, rd_wr_d;
    logic [ADD_LEN:0]    addr_q, addr_d;
    logic [ADD_LEN-1:0]  words_q, words_d;
    logic [ADD_LEN-1:0]  xfer_cnt_q, xfer_cnt_d;
    logic [ADD_LEN-1:0]  fetched_q, fetched_d;
    logic                fault_q, fault_d;
    logic [1:0]          occ_q, occ_d;
    logic [DATA_LEN-1:0] mem0_q, mem0_d, mem1_q, mem1_d;

    logic                in_xfer, active;
    logic                push, pop, overflow, underflow;
    logic [DATA_LEN-1:0] push_data;

    assign in_xfer    = (state_q == StXfer);
    assign active     = (state_q == StReq) || in_xfer;
    assign cmd_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign rqst       = active;
    assign rd_wr      = rd_wr_q;
    assign start_addr = addr_q;
    assign num_words  = words_q;
    assign snk_data   = mem0_q;
    assign dev_in     = mem0_q;

    assign snk_valid = rd_wr_q && busy && (occ_q != 2'd0);
    assign src_ready = !rd_wr_q && active && ((occ_q != 2'd2) || dma_ack)
                       && (fetched_q < words_q);

    // Read: room for the word the DMA may still send. Write: a word is on dev_in next cycle.
    always_comb begin
        dev_ack = 1'b0;
        if (in_xfer) begin
            if (rd_wr_q) dev_ack = (occ_q == 2'd0) || ((occ_q == 2'd1) && snk_ready);
            else         dev_ack = (occ_q == 2'd2) || ((occ_q == 2'd1) && !dma_ack);
        end
    end

    assign done = (state_q == StFin) && (!rd_wr_q || (occ_q == 2'd0));
    assign err  = done && ((xfer_cnt_q != words_q) || fault_q);

    assign push      = rd_wr_q ? (in_xfer && dma_ack) : (src_valid && src_ready);
    assign pop       = rd_wr_q ? (snk_valid && snk_ready)
                               : (in_xfer && dma_ack && (occ_q != 2'd0));
    assign push_data = rd_wr_q ? dev_out : src_data;
    assign overflow  = push && !pop && (occ_q == 2'd2);
    assign underflow = !rd_wr_q && in_xfer && dma_ack && (occ_q == 2'd0);

    always_comb begin
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        occ_d  = occ_q;
        if (pop) begin
            mem0_d = mem1_q;
            occ_d  = occ_q - 2'd1;
        end
        if (push && (occ_d != 2'd2)) begin
            if (occ_d == 2'd0) mem0_d = push_data;
            else               mem1_d = push_data;
            occ_d = occ_d + 2'd1;
        end
        // Leftover prefetched words are dropped when the transfer closes.
        if (done) occ_d = 2'd0;
    end

    always_comb begin
        state_d    = state_q;
        rd_wr_d    = rd_wr_q;
        addr_d     = addr_q;
        words_d    = words_q;
        xfer_cnt_d = xfer_cnt_q;
        fetched_d  = fetched_q;
        fault_d    = fault_q;
        if (push && !rd_wr_q) fetched_d = fetched_q + ADD_LEN'(1);
        if (overflow || underflow) fault_d = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    rd_wr_d    = cmd_rd_wr;
                    addr_d     = cmd_addr;
                    words_d    = cmd_words;
                    xfer_cnt_d = '0;
                    fetched_d  = '0;
                    fault_d    = 1'b0;
                    state_d    = StReq;
                end
            end
            StReq: state_d = StXfer;
            StXfer: begin
                if (dma_ack)  xfer_cnt_d = xfer_cnt_q + ADD_LEN'(1);
                if (end_flag) state_d = StFin;
            end
            StFin: begin
                if (done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rd_wr_q    <= 1'b0;
            addr_q     <= '0;
            words_q    <= '0;
            xfer_cnt_q <= '0;
            fetched_q  <= '0;
            fault_q    <= 1'b0;
            occ_q      <= 2'd0;
            mem0_q     <= '0;
            mem1_q     <= '0;
        end else begin
            state_q    <= state_d;
            rd_wr_q    <= rd_wr_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
            xfer_cnt_q <= xfer_cnt_d;
            fetched_q  <= fetched_d;
            fault_q    <= fault_d;
            occ_q      <= occ_d;
            mem0_q     <= mem0_d;
            mem1_q     <= mem1_d;
        end
    end

endmodule
